// File: rtl/program_loader.sv
// Instruction-store loader for the 2-bit paper processor: fills the store from a
// valid/ready stream, pads with HLT, pulses the PC reset, then serves fetches in RUN.
//
// state  | meaning
// IDLE   | waiting for start, store held
// LOAD   | accepting words from the instruction stream
// FILL   | padding remaining slots with HLT_OP
// PCRST  | pc_reset asserted for two cycles
// RUN    | processor executing, fetches served from the store
// ERROR  | illegal opcode received, waiting for start
module program_loader #(
   parameter int          ADDR_W = 2,
   parameter int          DEPTH  = 4,
   parameter logic [1:0]  HLT_OP = 2'b10,
   parameter logic [1:0]  ILL_OP = 2'b11
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_data,
   input  logic              in_last,
   output logic              pc_reset,
   output logic              run,
   input  logic              halted,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic [1:0]        fetch_data,
   output logic [ADDR_W:0]   word_count,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_FILL, S_PCRST, S_RUN, S_ERROR
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   WC_ONE    = (ADDR_W + 1)'(1);

   state_t              state_q, state_d;
   logic [1:0]          store_q [DEPTH];
   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W:0]     wc_q;
   logic                pcrst_cnt_q;
   logic                pc_reset_q;
   logic                done_q;

   logic accept;
   logic illegal;
   logic start_ok;

   assign accept   = (state_q == S_LOAD) && in_valid;
   assign illegal  = (in_data == ILL_OP);
   assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_ERROR));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_LOAD;
         S_LOAD: begin
            if (accept) begin
               if (illegal)                  state_d = S_ERROR;
               else if (addr_q == LAST_ADDR) state_d = S_PCRST;
               else if (in_last)             state_d = S_FILL;
            end
         end
         S_FILL:  if (addr_q == LAST_ADDR) state_d = S_PCRST;
         S_PCRST: if (pcrst_cnt_q == 1'b0) state_d = S_RUN;
         S_RUN:   if (halted) state_d = S_IDLE;
         S_ERROR: if (start) state_d = S_LOAD;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready   = (state_q == S_LOAD);
      run        = (state_q == S_RUN);
      err        = (state_q == S_ERROR);
      fetch_data = HLT_OP;
      if (state_q == S_RUN) fetch_data = store_q[fetch_addr];
   end

   // pc_reset is registered from the next state so it tracks PCRST exactly
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         addr_q      <= '0;
         wc_q        <= '0;
         pcrst_cnt_q <= 1'b0;
         pc_reset_q  <= 1'b0;
         done_q      <= 1'b0;
         for (int i = 0; i < DEPTH; i++) store_q[i] <= HLT_OP;
      end else begin
         pc_reset_q <= (state_d == S_PCRST);
         done_q     <= (state_q == S_RUN) && halted;
         if (start_ok) begin
            addr_q <= '0;
            wc_q   <= '0;
         end
         if (accept && !illegal) begin
            store_q[addr_q] <= in_data;
            addr_q          <= addr_q + ADDR_ONE;
            wc_q            <= wc_q + WC_ONE;
         end
         if (state_q == S_FILL) begin
            store_q[addr_q] <= HLT_OP;
            addr_q          <= addr_q + ADDR_ONE;
         end
         if ((state_q != S_PCRST) && (state_d == S_PCRST))
            pcrst_cnt_q <= 1'b1;
         else if ((state_q == S_PCRST) && (pcrst_cnt_q != 1'b0))
            pcrst_cnt_q <= pcrst_cnt_q - 1'b1;
      end
   end

   assign pc_reset   = pc_reset_q;
   assign done       = done_q;
   assign word_count = wc_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus queues expected events and probes,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_program_loader;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [1:0] in_data = 2'b00;
   logic       in_last = 1'b0;
   logic       pc_reset;
   logic       run;
   logic       halted = 1'b0;
   logic [1:0] fetch_addr = 2'b00;
   logic [1:0] fetch_data;
   logic [2:0] word_count;
   logic       done;
   logic       err;

   program_loader dut (
      .clock(clock), .reset_n(reset_n), .start(start),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .pc_reset(pc_reset), .run(run), .halted(halted),
      .fetch_addr(fetch_addr), .fetch_data(fetch_data),
      .word_count(word_count), .done(done), .err(err)
   );

   always #5 clock = ~clock;

   localparam int E_PCLEN = 0, E_RUNLAT = 1, E_RUNWC = 2, E_DONE = 3, E_ERR = 4;
   localparam int P_OUTS = 0, P_FETCH = 1, P_WC = 2;

   typedef struct {
      int    kind;
      int    exp;
      string name;
   } item_t;

   item_t evq[$];
   item_t prq[$];

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_ev(input int kind, input int act, input string name);
      item_t e;
      if (evq.size() == 0 || evq[0].kind != kind) begin
         checks++;
         errors++;
         $display("FAIL %s: unexpected event, value %0d at %0t", name, act, $time);
      end else begin
         e = evq.pop_front();
         check(e.name, act, e.exp);
      end
   endtask

   // monitor
   int   pc_len = 0;
   int   since_acc = 0;
   logic prev_pc = 1'b0, prev_run = 1'b0, prev_done = 1'b0, prev_err = 1'b0;

   always @(negedge clock) begin
      item_t p;
      int    act;
      while (prq.size() > 0) begin
         p = prq.pop_front();
         case (p.kind)
            P_OUTS:  act = int'({in_ready, pc_reset, run, done, err});
            P_FETCH: act = int'(fetch_data);
            default: act = int'(word_count);
         endcase
         check(p.name, act, p.exp);
      end
      if (prev_pc && !pc_reset) expect_ev(E_PCLEN, pc_len, "pc_reset_len");
      pc_len = pc_reset ? pc_len + 1 : 0;
      if (run && !prev_run) begin
         expect_ev(E_RUNLAT, since_acc, "run_latency");
         expect_ev(E_RUNWC, int'(word_count), "run_word_count");
      end
      if (done && !prev_done) expect_ev(E_DONE, int'({done, run}), "done_pulse");
      if (err && !prev_err) expect_ev(E_ERR, int'(word_count), "err_word_count");
      since_acc = (in_valid && in_ready) ? 0 : since_acc + 1;
      prev_pc   = pc_reset;
      prev_run  = run;
      prev_done = done;
      prev_err  = err;
   end

   // stimulus helpers
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic push_ev(input int kind, input int exp, input string name);
      evq.push_back('{kind, exp, name});
   endtask

   task automatic probe(input int kind, input int exp, input string name);
      prq.push_back('{kind, exp, name});
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic send(input logic [1:0] d, input logic l);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!in_ready && n < 20) begin
         cyc();
         n++;
      end
      cyc();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic expect_load(input int lat, input int wc);
      push_ev(E_PCLEN, 2, "pc_reset_len");
      push_ev(E_RUNLAT, lat, "run_latency");
      push_ev(E_RUNWC, wc, "run_word_count");
   endtask

   task automatic wait_run();
      int n = 0;
      while (!run && n < 40) begin
         cyc();
         n++;
      end
   endtask

   task automatic check_store(input logic [1:0] s0, input logic [1:0] s1,
                              input logic [1:0] s2, input logic [1:0] s3);
      logic [1:0] exp [4];
      exp = '{s0, s1, s2, s3};
      for (int a = 0; a < 4; a++) begin
         fetch_addr = 2'(a);
         probe(P_FETCH, int'(exp[a]), $sformatf("fetch_slot%0d", a));
         cyc();
      end
      fetch_addr = 2'b00;
   endtask

   task automatic do_halt();
      push_ev(E_DONE, 2, "done_pulse");
      halted = 1'b1;
      start  = 1'b1;
      cyc();
      halted = 1'b0;
      start  = 1'b0;
      repeat (2) cyc();
      probe(P_OUTS, 0, "outs_after_halt");
      cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      probe(P_OUTS, 0, "outs_in_reset");
      probe(P_FETCH, 2, "fetch_in_reset");
      repeat (2) cyc();
      reset_n = 1'b1;
      cyc();

      // full load, no FILL
      expect_load(2, 4);
      pulse_start();
      send(2'b00, 1'b0);
      send(2'b01, 1'b0);
      send(2'b00, 1'b0);
      send(2'b10, 1'b1);
      wait_run();
      check_store(2'b00, 2'b01, 2'b00, 2'b10);
      do_halt();
      probe(P_WC, 4, "wc_held_after_run");
      cyc();

      // short load with a gap, in_valid held through FILL/PCRST
      expect_load(4, 2);
      pulse_start();
      send(2'b00, 1'b0);
      cyc();
      send(2'b01, 1'b1);
      in_valid = 1'b1;
      in_data  = 2'b00;
      wait_run();
      in_valid = 1'b0;
      check_store(2'b00, 2'b01, 2'b10, 2'b10);
      do_halt();

      // illegal opcode, then recovery
      push_ev(E_ERR, 1, "err_word_count");
      pulse_start();
      send(2'b00, 1'b0);
      send(2'b11, 1'b1);
      fetch_addr = 2'b01;
      probe(P_OUTS, 1, "outs_in_error");
      probe(P_FETCH, 2, "fetch_in_error");
      cyc();
      fetch_addr = 2'b00;
      pulse_start();
      probe(P_OUTS, 16, "outs_reload");
      probe(P_WC, 0, "wc_cleared_on_start");
      cyc();
      expect_load(3, 3);
      send(2'b01, 1'b0);
      send(2'b00, 1'b0);
      send(2'b01, 1'b1);
      wait_run();
      check_store(2'b01, 2'b00, 2'b01, 2'b10);
      do_halt();

      // async reset mid-load
      pulse_start();
      send(2'b00, 1'b0);
      send(2'b01, 1'b0);
      #2;
      reset_n = 1'b0;
      probe(P_OUTS, 0, "outs_mid_load_reset");
      probe(P_WC, 0, "wc_mid_load_reset");
      cyc();
      reset_n = 1'b1;
      cyc();
      expect_load(5, 1);
      pulse_start();
      send(2'b10, 1'b1);
      wait_run();
      check_store(2'b10, 2'b10, 2'b10, 2'b10);
      do_halt();

      repeat (3) cyc();
      check("events_drained", evq.size(), 0);
      check("probes_drained", prq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
